// File: rtl/mvm_pkg.sv
// Shared constants and FSM state type for the 3x3 matrix-vector controller.
package mvm_pkg;
    localparam int MVM_N      = 3;
    localparam int MVM_NN     = MVM_N * MVM_N;
    localparam int MVM_ADDR_M = 4;
    localparam int MVM_ADDR_V = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_M,
        LOAD_V,
        CLEAR,
        MAC,
        WRITE,
        DRAIN,
        DONE
    } mvm_state_t;
endpackage

// File: rtl/mvm_stream_ctr.sv
// Wrapping up-counter 0..MAX; synchronous clear beats enable; tc_o flags the last value.
module mvm_stream_ctr #(
    parameter int W   = 4,
    parameter int MAX = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == MAX_V) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == MAX_V);
endmodule

// File: rtl/mvm_controller.sv
// Sequencer for the 3x3 MVM datapath: load 12 bytes (in_valid/in_ready), 5 cycles per row, drain 3 words (out_valid/out_ready).
// MVM_OVERLAP_EN folds the per-row accumulator clear into WRITE, cutting compute from 15 to 13 cycles.
module mvm_controller
    import mvm_pkg::*;
#(
    parameter int N      = MVM_N,
    parameter int ADDR_M = MVM_ADDR_M,
    parameter int ADDR_V = MVM_ADDR_V
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_M-1:0] addr_x,
    output logic              wr_en_x,
    output logic [ADDR_V-1:0] addr_a,
    output logic              wr_en_a,
    output logic [ADDR_V-1:0] addr_y,
    output logic              wr_en_y,
    output logic              clear_acc
);
    localparam logic [ADDR_M-1:0] N_M    = ADDR_M'(N);
    localparam logic [ADDR_M-1:0] LAST_V = ADDR_M'(N - 1);

    mvm_state_t state_q, state_d;

    logic [ADDR_M-1:0] idx;
    logic [ADDR_V-1:0] row, col, out_idx;
    logic idx_en, idx_clr, idx_tc;
    logic row_en, row_tc, col_en, col_tc, out_en, out_tc;
    logic idle;

    assign idle = (state_q == IDLE);
    assign busy = ~idle;

    mvm_stream_ctr #(.W(ADDR_M), .MAX(N*N-1)) u_idx (
        .clk(clk), .reset(reset), .clr_i(idle | idx_clr), .en_i(idx_en), .cnt_o(idx), .tc_o(idx_tc)
    );
    mvm_stream_ctr #(.W(ADDR_V), .MAX(N-1)) u_row (
        .clk(clk), .reset(reset), .clr_i(idle), .en_i(row_en), .cnt_o(row), .tc_o(row_tc)
    );
    mvm_stream_ctr #(.W(ADDR_V), .MAX(N-1)) u_col (
        .clk(clk), .reset(reset), .clr_i(idle), .en_i(col_en), .cnt_o(col), .tc_o(col_tc)
    );
    mvm_stream_ctr #(.W(ADDR_V), .MAX(N-1)) u_out (
        .clk(clk), .reset(reset), .clr_i(idle), .en_i(out_en), .cnt_o(out_idx), .tc_o(out_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        addr_x    = '0;
        wr_en_x   = 1'b0;
        addr_a    = '0;
        wr_en_a   = 1'b0;
        addr_y    = '0;
        wr_en_y   = 1'b0;
        clear_acc = 1'b0;
        idx_en    = 1'b0;
        idx_clr   = 1'b0;
        row_en    = 1'b0;
        col_en    = 1'b0;
        out_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD_M;
            end
            LOAD_M: begin
                in_ready = 1'b1;
                addr_x   = idx;
                if (in_valid) begin
                    wr_en_x = 1'b1;
                    idx_en  = 1'b1;
                    // idx wraps to 0 on its own, ready for the vector bytes
                    if (idx_tc) state_d = LOAD_V;
                end
            end
            LOAD_V: begin
                in_ready = 1'b1;
                addr_a   = idx[ADDR_V-1:0];
                if (in_valid) begin
                    wr_en_a = 1'b1;
                    idx_en  = 1'b1;
                    if (idx == LAST_V) begin
                        idx_clr = 1'b1;
                        state_d = CLEAR;
                    end
                end
            end
            CLEAR: begin
                clear_acc = 1'b1;
                state_d   = MAC;
            end
            MAC: begin
                addr_x  = ADDR_M'(row) * N_M + ADDR_M'(col);
                addr_a  = col;
                col_en  = 1'b1;
                if (col_tc) state_d = WRITE;
            end
            WRITE: begin
                // result memory samples acc at this edge; row wraps to 0 after the last row
                wr_en_y = 1'b1;
                addr_y  = row;
                row_en  = 1'b1;
                if (row_tc) begin
                    state_d = DRAIN;
                end else begin
`ifdef MVM_OVERLAP_EN
                    clear_acc = 1'b1;
                    state_d   = MAC;
`else
                    state_d   = CLEAR;
`endif
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                addr_y    = out_idx;
                if (out_ready) begin
                    out_en = 1'b1;
                    if (out_tc) state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mvm_controller.sv
// Bench for mvm_controller: behavioural datapath around the DUT, table-driven and random jobs vs an arithmetic reference.
module tb_mvm_controller;
    import mvm_pkg::*;

`ifdef MVM_OVERLAP_EN
    localparam int LAT = 13;
`else
    localparam int LAT = 15;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, in_valid, out_ready;
    logic in_ready, out_valid, busy, done, wr_en_x, wr_en_a, wr_en_y, clear_acc;
    logic [MVM_ADDR_M-1:0] addr_x;
    logic [MVM_ADDR_V-1:0] addr_a, addr_y;

    mvm_controller dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done),
        .addr_x(addr_x), .wr_en_x(wr_en_x),
        .addr_a(addr_a), .wr_en_a(wr_en_a),
        .addr_y(addr_y), .wr_en_y(wr_en_y),
        .clear_acc(clear_acc)
    );

    // Datapath environment: memories and accumulator following the timing contract
    logic [7:0]        data_in;
    logic signed [7:0] mem_x [16];
    logic signed [7:0] mem_a [4];
    logic [15:0]       mem_y [4];
    logic [15:0]       acc = '0;
    logic [15:0]       prod, data_out;

    always_comb prod = 16'(int'(mem_x[addr_x]) * int'(mem_a[addr_a]));
    assign data_out = mem_y[addr_y];

    always @(posedge clk) begin
        if (wr_en_x) mem_x[addr_x] <= data_in;
        if (wr_en_a) mem_a[addr_a] <= data_in;
        if (wr_en_y) mem_y[addr_y] <= acc;
        acc <= clear_acc ? 16'h0 : acc + prod;
    end

    int n_wx = 0, n_wa = 0, n_wy = 0, n_done = 0;
    always @(posedge clk) begin
        if (wr_en_x) n_wx <= n_wx + 1;
        if (wr_en_a) n_wa <= n_wa + 1;
        if (wr_en_y) n_wy <= n_wy + 1;
        if (done)    n_done <= n_done + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] outs_vec();
        return {in_ready, out_valid, busy, done, wr_en_x, wr_en_a, wr_en_y, clear_acc,
                addr_x, addr_a, addr_y};
    endfunction

    function automatic logic [2:0][15:0] ref_mvm(input logic [8:0][7:0] m, input logic [2:0][7:0] v);
        logic [2:0][15:0] y;
        int s;
        for (int r = 0; r < 3; r++) begin
            s = 0;
            for (int c = 0; c < 3; c++) s += int'($signed(m[3*r+c])) * int'($signed(v[c]));
            y[r] = s[15:0];
        end
        return y;
    endfunction

    task automatic start_job();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load(input logic [8:0][7:0] m, input logic [2:0][7:0] v, input bit gap, input bit poke);
        logic [7:0] b [12];
        int k;
        int cyc;
        bit tog;
        k = 0; cyc = 0; tog = 1'b0;
        for (int i = 0; i < 9; i++) b[i] = m[i];
        for (int i = 0; i < 3; i++) b[9+i] = v[i];
        while (k < 12 && cyc < 300) begin
            in_valid = gap ? tog : 1'b1;
            tog      = ~tog;
            data_in  = b[k];
            start    = poke && (k >= 9);
            #1;
            if (in_valid && in_ready) k++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("load_bytes_accepted", k, 12);
    endtask

    task automatic wait_valid(output int lat);
        bit bad;
        bad = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) bad = 1'b1;
            lat++;
            @(negedge clk);
        end
        chk("in_ready_low_compute", bad, 0);
    endtask

    task automatic drain(input int st_at, input int st_len, input bit poke, output logic [2:0][15:0] res);
        int n;
        int d;
        bit bad;
        n = 0; d = 0; bad = 1'b0;
        res = '0;
        while (n < 3 && d < 300) begin
            out_ready = !(d >= st_at && d < st_at + st_len);
            start     = poke;
            #1;
            if (in_ready) bad = 1'b1;
            if (out_valid && out_ready) begin
                res[n] = data_out;
                n++;
            end
            @(negedge clk);
            d++;
        end
        out_ready = 1'b0;
        start     = 1'b0;
        chk("in_ready_low_drain", bad, 0);
    endtask

    task automatic run_job(input string tag, input logic [8:0][7:0] m, input logic [2:0][7:0] v,
                           input bit gap, input int st_at, input int st_len, input bit poke,
                           input logic [2:0][15:0] exp);
        int wx0, wa0, wy0, dn0, lat;
        logic [2:0][15:0] res;
        wx0 = n_wx; wa0 = n_wa; wy0 = n_wy; dn0 = n_done;
        start_job();
        chk({tag, "_busy_in_load"}, busy, 1);
        load(m, v, gap, poke);
        wait_valid(lat);
        chk({tag, "_latency"}, lat, LAT);
        drain(st_at, st_len, poke, res);
        for (int r = 0; r < 3; r++) chk($sformatf("%s_y%0d", tag, r), res[r], exp[r]);
        chk({tag, "_done_pulse"}, done, 1);
        @(negedge clk);
        chk({tag, "_done_low"}, done, 0);
        chk({tag, "_idle_after"}, busy, 0);
        chk({tag, "_wr_x_count"}, n_wx - wx0, 9);
        chk({tag, "_wr_a_count"}, n_wa - wa0, 3);
        chk({tag, "_wr_y_count"}, n_wy - wy0, 3);
        chk({tag, "_done_count"}, n_done - dn0, 1);
    endtask

    typedef struct {
        logic [8:0][7:0]  m;
        logic [2:0][7:0]  v;
        bit               gap;
        int               st_at;
        int               st_len;
        bit               poke;
        logic [2:0][15:0] exp;
    } vec_t;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [3];
        logic [8:0][7:0] m;
        logic [2:0][7:0] v;

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data_in = '0;

        // Identity matrix, vector [1,2,3]
        tbl[0].m = '0;
        tbl[0].m[0] = 8'd1; tbl[0].m[4] = 8'd1; tbl[0].m[8] = 8'd1;
        tbl[0].v = '0;
        tbl[0].v[0] = 8'd1; tbl[0].v[1] = 8'd2; tbl[0].v[2] = 8'd3;
        tbl[0].gap = 1'b0; tbl[0].st_at = 0; tbl[0].st_len = 0; tbl[0].poke = 1'b0;
        tbl[0].exp[0] = 16'd1; tbl[0].exp[1] = 16'd2; tbl[0].exp[2] = 16'd3;
        // All -128: 3*16384 wraps to 0xC000; start poked in LOAD_V and DRAIN
        for (int i = 0; i < 9; i++) tbl[1].m[i] = 8'h80;
        for (int i = 0; i < 3; i++) tbl[1].v[i] = 8'h80;
        tbl[1].gap = 1'b0; tbl[1].st_at = 0; tbl[1].st_len = 0; tbl[1].poke = 1'b1;
        for (int i = 0; i < 3; i++) tbl[1].exp[i] = 16'hC000;
        // [[1..9]] x [1,-1,2] with input gaps and a 4-cycle drain stall
        for (int i = 0; i < 9; i++) tbl[2].m[i] = 8'(i + 1);
        tbl[2].v[0] = 8'd1; tbl[2].v[1] = 8'hFF; tbl[2].v[2] = 8'd2;
        tbl[2].gap = 1'b1; tbl[2].st_at = 1; tbl[2].st_len = 4; tbl[2].poke = 1'b0;
        tbl[2].exp[0] = 16'd5; tbl[2].exp[1] = 16'd11; tbl[2].exp[2] = 16'd17;

        repeat (3) @(negedge clk);
        chk("reset_outputs", outs_vec(), 16'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_outputs_after_reset", outs_vec(), 16'h0);

        for (int t = 0; t < 3; t++)
            run_job($sformatf("tbl%0d", t), tbl[t].m, tbl[t].v, tbl[t].gap,
                    tbl[t].st_at, tbl[t].st_len, tbl[t].poke, tbl[t].exp);

        // Abort during MAC of row 1, then a fresh job must be correct
        for (int i = 0; i < 9; i++) m[i] = 8'($urandom);
        for (int i = 0; i < 3; i++) v[i] = 8'($urandom);
        start_job();
        load(m, v, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        chk("abort_busy_mid_mac", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_outputs_zero", outs_vec(), 16'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_still_idle", busy, 0);
        for (int i = 0; i < 9; i++) m[i] = 8'($urandom);
        for (int i = 0; i < 3; i++) v[i] = 8'($urandom);
        run_job("after_abort", m, v, 1'b1, 0, 2, 1'b0, ref_mvm(m, v));

        for (int j = 0; j < 5; j++) begin
            for (int i = 0; i < 9; i++) m[i] = 8'($urandom);
            for (int i = 0; i < 3; i++) v[i] = 8'($urandom);
            run_job($sformatf("rnd%0d", j), m, v, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 4)),
                    1'($urandom_range(0, 1)), ref_mvm(m, v));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
